// File: rtl/tiny_nn_pkg.sv
// rtl/tiny_nn_pkg.sv - shared command encodings and driver state for tiny_nn
package tiny_nn_pkg;

    localparam logic [3:0]  CmdOpConvolve = 4'h1;
    // Opcode 0 never decodes as a convolve, so the bus is inert while idle.
    localparam logic [15:0] CmdIdleWord   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_PARAM = 2'd2,
        ST_EXEC  = 2'd3
    } drv_state_e;

endpackage

// File: rtl/tiny_nn_host_driver.sv
// rtl/tiny_nn_host_driver.sv - serialises convolve requests onto the tiny_nn bus and reassembles results
module tiny_nn_host_driver
    import tiny_nn_pkg::*;
#(
    parameter int CountWidth = 12,
    parameter int ResultSkip = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CountWidth-1:0] count_i,
    input  logic                  in_valid_i,
    input  logic [15:0]           in_data_i,
    output logic                  in_ready_o,
    output logic [15:0]           tnn_data_o,
    input  logic [7:0]            tnn_data_i,
    output logic                  res_valid_o,
    output logic [15:0]           res_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  underrun_o
);

    localparam logic [CountWidth-1:0] SkipPairs = CountWidth'(ResultSkip);

    drv_state_e            state, state_next;
    logic [CountWidth-1:0] n_q;
    logic [CountWidth-1:0] pair_q;
    logic [2:0]            k_q;
    logic                  phase_q;
    logic [7:0]            low_q;
    logic                  final_cycle;
    logic [15:0]           slot_word;

    // A missing host word still occupies its bus slot; the accelerator cannot stall.
    assign slot_word = in_valid_i ? in_data_i : 16'h0000;
    assign busy_o    = (state != ST_IDLE);

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        final_cycle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) state_next = ST_CMD;
            end
            ST_CMD: begin
                in_ready_o = 1'b1;
                state_next = ST_PARAM;
            end
            ST_PARAM: begin
                in_ready_o = 1'b1;
                if (k_q == 3'd7) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                final_cycle = phase_q && (pair_q == n_q);
                in_ready_o  = !final_cycle;
                if (final_cycle) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            n_q         <= '0;
            pair_q      <= '0;
            k_q         <= 3'd0;
            phase_q     <= 1'b0;
            low_q       <= 8'h00;
            tnn_data_o  <= CmdIdleWord;
            res_data_o  <= 16'h0000;
            res_valid_o <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
        end else begin
            state       <= state_next;
            done_o      <= final_cycle;
            res_valid_o <= 1'b0;

            if (state == ST_IDLE && start_i) begin
                n_q        <= count_i;
                underrun_o <= 1'b0;
                tnn_data_o <= 16'({CmdOpConvolve, count_i});
            end else if (in_ready_o) begin
                tnn_data_o <= slot_word;
                if (!in_valid_i) underrun_o <= 1'b1;
            end else if (final_cycle) begin
                tnn_data_o <= CmdIdleWord;
            end

            if (state == ST_CMD) begin
                k_q <= 3'd0;
            end else if (state == ST_PARAM) begin
                k_q <= k_q + 3'd1;
            end

            if (state == ST_PARAM) begin
                phase_q <= 1'b0;
                pair_q  <= '0;
            end else if (state == ST_EXEC) begin
                phase_q <= ~phase_q;
                // Holding the counter on the final pair keeps N = max legal from wrapping.
                if (phase_q && !final_cycle) pair_q <= pair_q + 1'b1;
                if (!phase_q) begin
                    low_q <= tnn_data_i;
                end else if (pair_q >= SkipPairs) begin
                    res_data_o  <= {tnn_data_i, low_q};
                    res_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tiny_nn_host_driver.sv
// tb/tb_tiny_nn_host_driver.sv - directed self-checking bench for tiny_nn_host_driver
module tb_tiny_nn_host_driver;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [11:0] count_i;
    logic        in_valid_i;
    logic [15:0] in_data_i;
    logic        in_ready_o;
    logic [15:0] tnn_data_o;
    logic [7:0]  tnn_data_i;
    logic        res_valid_o;
    logic [15:0] res_data_o;
    logic        busy_o;
    logic        done_o;
    logic        underrun_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] words   [0:63];
    logic [15:0] bus_log [0:63];
    logic        rv_log  [0:63];
    logic [15:0] rd_log  [0:63];
    logic        done_log[0:63];
    logic        busy_log[0:63];
    logic        ur_log  [0:63];
    int          rv_cnt;

    always #5 clk_i = ~clk_i;

    tiny_nn_host_driver #(.CountWidth(12), .ResultSkip(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .count_i(count_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .tnn_data_o(tnn_data_o), .tnn_data_i(tnn_data_i), .res_valid_o(res_valid_o),
        .res_data_o(res_data_o), .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o)
    );

    // Cycle 0 presents start; log index c holds the outputs seen during cycle c.
    task automatic drive_txn(input int n, input int drop_w, input bit hold,
                             input logic [7:0] b0, input logic [7:0] b1, input int ncyc);
        rv_cnt = 0;
        @(negedge clk_i);
        start_i = 1'b1; count_i = 12'(n); in_valid_i = 1'b0; tnn_data_i = 8'h00;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk_i);
            bus_log[c] = tnn_data_o; rv_log[c] = res_valid_o; rd_log[c] = res_data_o;
            done_log[c] = done_o; busy_log[c] = busy_o; ur_log[c] = underrun_o;
            if (res_valid_o) rv_cnt++;
            start_i = hold;
            if (c - 1 < 10 + 2 * n) begin
                in_valid_i = (c - 1 != drop_w);
                in_data_i  = words[c - 1];
            end else begin
                in_valid_i = hold;
                in_data_i  = 16'h5555;
            end
            if (c >= 10 && c <= 11 + 2 * n) tnn_data_i = ((c - 10) % 2 == 0) ? b0 : b1;
            else tnn_data_i = 8'h00;
        end
        start_i = 1'b0; in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; count_i = '0; in_valid_i = 1'b0;
        in_data_i = '0; tnn_data_i = '0;
        repeat (3) @(negedge clk_i);
        total += 7;
        if (tnn_data_o !== 16'h0000) begin bad++; $display("FAIL rst_bus got=%h want=0000", tnn_data_o); end
        if (busy_o !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        if (in_ready_o !== 1'b0)  begin bad++; $display("FAIL rst_ready got=%b want=0", in_ready_o); end
        if (res_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", res_valid_o); end
        if (done_o !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b want=0", done_o); end
        if (underrun_o !== 1'b0)  begin bad++; $display("FAIL rst_ur got=%b want=0", underrun_o); end
        if (res_data_o !== 16'h0) begin bad++; $display("FAIL rst_rd got=%h want=0000", res_data_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_n0();
        for (int i = 0; i < 8; i++) words[i] = 16'(i + 1);
        words[8] = 16'hA000; words[9] = 16'hB000;
        drive_txn(0, -1, 1'b0, 8'h00, 8'h00, 14);
        total++; if (bus_log[1] !== 16'h1000) begin bad++; $display("FAIL n0_cmd got=%h want=1000", bus_log[1]); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus_log[2 + i] !== 16'(i + 1)) begin bad++; $display("FAIL n0_param%0d got=%h want=%h", i, bus_log[2 + i], 16'(i + 1)); end
        end
        total++; if (bus_log[10] !== 16'hA000) begin bad++; $display("FAIL n0_val0 got=%h want=a000", bus_log[10]); end
        total++; if (bus_log[11] !== 16'hB000) begin bad++; $display("FAIL n0_val1 got=%h want=b000", bus_log[11]); end
        total++; if (bus_log[12] !== 16'h0000) begin bad++; $display("FAIL n0_idle got=%h want=0000", bus_log[12]); end
        total++; if (done_log[12] !== 1'b1 || done_log[11] !== 1'b0 || done_log[13] !== 1'b0) begin
            bad++; $display("FAIL n0_done got=%b%b%b want=010", done_log[11], done_log[12], done_log[13]); end
        total++; if (busy_log[11] !== 1'b1 || busy_log[12] !== 1'b0) begin
            bad++; $display("FAIL n0_busy got=%b%b want=10", busy_log[11], busy_log[12]); end
        total++; if (rv_cnt !== 0) begin bad++; $display("FAIL n0_rvcnt got=%0d want=0", rv_cnt); end
        total++; if (ur_log[12] !== 1'b0) begin bad++; $display("FAIL n0_ur got=%b want=0", ur_log[12]); end
    endtask

    task automatic test_results();
        for (int i = 0; i < 16; i++) words[i] = 16'h0100 + 16'(i);
        drive_txn(3, -1, 1'b0, 8'h11, 8'h22, 19);
        total++; if (rv_cnt !== 2) begin bad++; $display("FAIL res_cnt got=%0d want=2", rv_cnt); end
        total++; if (rv_log[16] !== 1'b1 || rd_log[16] !== 16'h2211) begin
            bad++; $display("FAIL res_first got=%b/%h want=1/2211", rv_log[16], rd_log[16]); end
        total++; if (rv_log[18] !== 1'b1 || rd_log[18] !== 16'h2211) begin
            bad++; $display("FAIL res_second got=%b/%h want=1/2211", rv_log[18], rd_log[18]); end
        total++; if (done_log[18] !== 1'b1) begin bad++; $display("FAIL res_done got=%b want=1", done_log[18]); end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 16; i++) words[i] = 16'hC000 + 16'(i);
        drive_txn(2, 11, 1'b0, 8'h00, 8'h00, 17);
        total++; if (bus_log[12] !== 16'hC00A) begin bad++; $display("FAIL ur_val2 got=%h want=c00a", bus_log[12]); end
        total++; if (bus_log[13] !== 16'h0000) begin bad++; $display("FAIL ur_slot got=%h want=0000", bus_log[13]); end
        total++; if (bus_log[14] !== 16'hC00C) begin bad++; $display("FAIL ur_val4 got=%h want=c00c", bus_log[14]); end
        total++; if (ur_log[12] !== 1'b0 || ur_log[13] !== 1'b1) begin
            bad++; $display("FAIL ur_rise got=%b%b want=01", ur_log[12], ur_log[13]); end
        repeat (4) @(negedge clk_i);
        total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL ur_sticky got=%b want=1", underrun_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) words[i] = 16'h0A00 + 16'(i);
        drive_txn(0, -1, 1'b1, 8'h00, 8'h00, 26);
        total++; if (ur_log[1] !== 1'b0) begin bad++; $display("FAIL b2b_urclr got=%b want=0", ur_log[1]); end
        total++; if (done_log[12] !== 1'b1 || bus_log[12] !== 16'h0000) begin
            bad++; $display("FAIL b2b_done1 got=%b/%h want=1/0000", done_log[12], bus_log[12]); end
        total++; if (bus_log[13] !== 16'h1000) begin bad++; $display("FAIL b2b_cmd2 got=%h want=1000", bus_log[13]); end
        total++; if (done_log[24] !== 1'b1 || bus_log[25] !== 16'h1000) begin
            bad++; $display("FAIL b2b_cmd3 got=%b/%h want=1/1000", done_log[24], bus_log[25]); end
    endtask

    task automatic test_reset_mid();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        start_i = 1'b1; count_i = 12'd1; in_valid_i = 1'b1; in_data_i = 16'h7777;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++; if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL mid_param got=%b%b want=11", busy_o, in_ready_o); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1; in_valid_i = 1'b0;
        total += 3;
        if (tnn_data_o !== 16'h0000) begin bad++; $display("FAIL mid_bus got=%h want=0000", tnn_data_o); end
        if (busy_o !== 1'b0)         begin bad++; $display("FAIL mid_busy got=%b want=0", busy_o); end
        if (in_ready_o !== 1'b0)     begin bad++; $display("FAIL mid_ready got=%b want=0", in_ready_o); end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_n0();
        test_results();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tiny_nn_host_driver.md
# tiny_nn_host_driver

Host-side driver for the tiny_nn accelerator's 16-bit-in / 8-bit-out bus. It takes a convolve request (pair count plus a stream of parameter and value words) from the host and serialises it onto the accelerator input bus as one command word, 8 parameter words and 2(N+1) value words. It samples the byte-wide accelerator output during execution and reassembles 16-bit accumulate results for the host. It sits between the host/test harness and the accelerator's `data_i`/`data_o` pins.

## Interface

Parameters:
- `CountWidth`, 12: width of the pair-count field.
- `ResultSkip`, 2: number of leading exec pairs whose output is discarded, matching the core accumulate pipeline depth.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, synchronous, active-low.
- `start_i`  in  1: start a convolve; sampled only in Idle.
- `count_i`  in  CountWidth: N; the transaction has N+1 exec pairs.
- `in_valid_i`  in  1: host word valid.
- `in_data_i`  in  16: 8 parameter words, then 2(N+1) value words.
- `in_ready_o`  out  1: driver consumes `in_data_i` this cycle.
- `tnn_data_o`  out  16: registered; wired to the accelerator `data_i`.
- `tnn_data_i`  in  8: wired from the accelerator `data_o`.
- `res_valid_o`  out  1: one-cycle pulse when a result is available.
- `res_data_o`  out  16: result as {high byte, low byte}.
- `busy_o`  out  1: transaction in progress.
- `done_o`  out  1: one-cycle pulse after the last exec cycle.
- `underrun_o`  out  1: sticky flag; cleared on accepted start.

## Operation

- States: Idle, Cmd, Param, Exec.
  - The state names the word currently on `tnn_data_o`.
  - Each word is accepted from the host one cycle before it appears on the bus.
- Idle
  - `tnn_data_o` = `CmdIdleWord`.
  - On `start_i`: latch N, clear `underrun_o`, load `{CmdOpConvolve, N}`, go to Cmd.
- Cmd (1 cycle)
  - `in_ready_o` = 1; the accepted word becomes param 0.
  - Go to Param with param index k = 0.
- Param (8 cycles, k = 0..7)
  - `in_ready_o` = 1; the accepted word is param k+1, or value 0 when k = 7.
  - At k = 7 go to Exec with phase = 0 and pair = 0.
- Exec (2(N+1) cycles; phase toggles every cycle)
  - `in_ready_o` = 1 in every Exec cycle except the final one (phase 1 of pair N).
  - Final cycle: load `CmdIdleWord`, pulse `done_o` next cycle, go to Idle.
  - pair increments after each phase-1 cycle.
- Underrun: when `in_ready_o`=1 and `in_valid_i`=0, drive 0x0000 for that slot and set `underrun_o`. The sequence never stalls, because the accelerator has no backpressure.
- Result capture (Exec only):
  - phase 0: latch `tnn_data_i` as the low byte.
  - phase 1: if pair ≥ `ResultSkip`, register {`tnn_data_i`, low byte} into `res_data_o` and pulse `res_valid_o`.
  - Result count = max(0, N+1−`ResultSkip`).
- `start_i` outside Idle is ignored.
- `busy_o` = 1 in Cmd, Param and Exec.
- Reset: Idle.
  - `tnn_data_o` = `CmdIdleWord`; `res_data_o` = 0.
  - `in_ready_o`, `res_valid_o`, `busy_o`, `done_o`, `underrun_o` = 0.
  - Driver and accelerator resets are asserted together. Resetting the driver alone mid-transaction returns it to Idle, and the accelerator result is undefined.

## Timing

- Start accepted at cycle 0 → command on the bus at cycle 1, params at cycles 2..9, values at cycles 10..11+2N.
- `done_o` pulses at cycle 12+2N; `busy_o` falls the same cycle.
- Earliest next start is accepted at cycle 12+2N.
- `res_valid_o` rises the cycle after the phase-1 sample.
- No combinational path from `tnn_data_i` to any output.
- Pair counter is CountWidth bits, compared against the latched N. N = 4095 is legal; the counter does not wrap.

## Structure

- `tiny_nn_pkg` holds `CmdOpConvolve` (existing) and a new `CmdIdleWord`, guaranteed not to decode as `CmdOpConvolve`. It also holds the driver state enum.
- Single module, no sub-modules.

## Test plan

- N=0, params 0x0001..0x0008, values 0xA000, 0xB000, valid always → bus shows `{CmdOpConvolve,0}`, 8 params, 2 values; `done_o` at cycle 12; no `res_valid_o` (ResultSkip=2); `underrun_o`=0.
- N=3, 8 values, `tnn_data_i` driven 0x11/0x22 alternating → exactly 2 `res_valid_o` pulses, each `res_data_o`=0x2211, one cycle after exec cycles 5 and 7.
- `in_valid_i` dropped for value 3 in N=2 → bus carries 0x0000 in that slot; `underrun_o` set and held until the next start.
- `start_i` held high continuously → back-to-back transactions; second command on the bus exactly 1 cycle after `done_o`.
- `rst_ni` low during Param → next cycle: Idle, `tnn_data_o`=`CmdIdleWord`, `busy_o`=0, `in_ready_o`=0.
- Closed loop against tiny_nn_top with N=4 → results match a reference model of the convolve.
